// File: rtl/calltrace_snap.sv
// calltrace_snap : post-mortem snapshot engine for a calltrace stack.
//
// A hardware trigger (rising edge of trig) or a software trigger freezes the
// calltrace stack. The engine then reads the stack status and every stacked
// LNK value through the calltrace IO port as a bus master, keeps them in a
// local buffer and unfreezes the stack. Software reads the held snapshot
// later through the CPU slave port. Only the first fault is captured: while a
// snapshot is valid or a dump is running, further triggers are dropped.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   trig                        hardware trigger (level, rising edge used)
//   ct_req / ct_gnt             bus request / grant towards the calltrace IO mux
//   ct_stb, ct_we, ct_addr      registered master strobe, write, address (0 data, 1 ctrl)
//   ct_dout                     registered master write data
//   ct_din, ct_ack              calltrace read data and same-cycle acknowledge
//   stb, we, addr, data_in      CPU slave access
//   data_out, ack               CPU read data (0 when not reading), ack = stb
//
// CPU map
//   addr 0 wr : bit0 clear (valid, rptr), bit1 software trigger
//   addr 0 rd : {valid, busy, trunc, ovfl, 3'b0, pid[4:0], 12'b0, count[7:0]}
//   addr 1 wr : rptr <= data_in[7:0]
//   addr 1 rd : {8'b0, buf[rptr]}, rptr then advances and wraps at num_slots-1
module calltrace_snap #(
   parameter int num_slots = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        trig,
   output logic        ct_req,
   input  logic        ct_gnt,
   output logic        ct_stb,
   output logic        ct_we,
   output logic        ct_addr,
   output logic [23:0] ct_dout,
   input  logic [31:0] ct_din,
   input  logic        ct_ack,
   input  logic        stb,
   input  logic        we,
   input  logic [1:0]  addr,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        ack
);

   localparam int          IW           = (num_slots > 1) ? $clog2(num_slots) : 1;
   localparam int          DEPTH        = 1 << IW;
   localparam logic [7:0]  SLOTS        = 8'(num_slots);
   localparam logic [7:0]  LAST         = 8'(num_slots - 1);
   localparam logic [23:0] CMD_FREEZE   = 24'h000004;
   localparam logic [23:0] CMD_UNFREEZE = 24'h000008;

   typedef enum logic [2:0] {S_IDLE, S_FREEZE, S_STAT, S_READ, S_UNFREEZE} state_t;

   state_t      r_state;
   logic        r_wait;      // a read/write strobe was on the bus last cycle
   logic        r_stb, r_we, r_addr;
   logic [23:0] r_dout;
   logic        r_trig_q;
   logic        r_valid, r_busy, r_trunc, r_ovfl;
   logic [4:0]  r_pid;
   logic [7:0]  r_count, r_n, r_idx, r_rptr;
   logic [23:0] r_buf [DEPTH];

   logic        w_wr0, w_wr1, w_rd1, w_clr, w_swtrig, w_hwtrig, w_accept;
   logic        w_buf_we, w_last_rd;
   logic [7:0]  w_st_n, w_idx_nxt;
   logic [23:0] w_buf_rd;
   logic        w_unused_ok;

   // Stack depth reported by calltrace, limited to what the buffer holds.
   function automatic logic [7:0] sat_depth(input logic [7:0] c);
      return (c > SLOTS) ? SLOTS : c;
   endfunction

   assign w_wr0     = stb & we & (addr == 2'd0);
   assign w_wr1     = stb & we & (addr == 2'd1);
   assign w_rd1     = stb & ~we & (addr == 2'd1);
   assign w_clr     = w_wr0 & data_in[0];
   assign w_swtrig  = w_wr0 & data_in[1];
   assign w_hwtrig  = trig & ~r_trig_q;
   // Clear takes effect before a trigger carried in the same write.
   assign w_accept  = (r_state == S_IDLE) & (w_hwtrig | w_swtrig) & ~(r_valid & ~w_clr);
   assign w_st_n    = sat_depth(ct_din[15:8]);
   assign w_idx_nxt = r_idx + 8'd1;
   assign w_last_rd = (w_idx_nxt == r_n);
   assign w_buf_we  = (r_state == S_READ) & r_wait & ct_ack;
   assign w_buf_rd  = (r_rptr < SLOTS) ? r_buf[r_rptr[IW-1:0]] : 24'h000000;
   assign w_unused_ok = &{1'b0, ct_din[31:29], data_in[31:8]};

   assign ct_req  = (r_state != S_IDLE);
   assign ct_stb  = r_stb;
   assign ct_we   = r_we;
   assign ct_addr = r_addr;
   assign ct_dout = r_dout;
   assign ack     = stb;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_wait   <= 1'b0;
         r_stb    <= 1'b0;
         r_we     <= 1'b0;
         r_addr   <= 1'b0;
         r_dout   <= 24'h000000;
         r_trig_q <= 1'b0;
         r_valid  <= 1'b0;
         r_busy   <= 1'b0;
         r_trunc  <= 1'b0;
         r_ovfl   <= 1'b0;
         r_pid    <= 5'd0;
         r_count  <= 8'd0;
         r_n      <= 8'd0;
         r_idx    <= 8'd0;
         r_rptr   <= 8'd0;
      end else begin
         r_trig_q <= trig;
         r_stb    <= 1'b0;

         if (w_clr) begin
            r_rptr <= 8'd0;
            if (r_state == S_IDLE) r_valid <= 1'b0;
         end else if (w_wr1) begin
            r_rptr <= data_in[7:0];
         end else if (w_rd1) begin
            r_rptr <= (r_rptr >= LAST) ? 8'd0 : r_rptr + 8'd1;
         end

         // Each state first retires the strobe issued last cycle (ack is
         // same-cycle), then issues the next one if granted. Without ack the
         // transaction is simply reissued.
         case (r_state)
            S_IDLE: begin
               r_wait <= 1'b0;
               if (w_accept) begin
                  r_state <= S_FREEZE;
                  r_busy  <= 1'b1;
               end
            end
            S_FREEZE: begin
               if (ct_gnt) begin
                  r_stb   <= 1'b1;
                  r_we    <= 1'b1;
                  r_addr  <= 1'b1;
                  r_dout  <= CMD_FREEZE;
                  r_state <= S_STAT;
                  r_wait  <= 1'b0;
               end
            end
            S_STAT: begin
               if (r_wait && ct_ack) begin
                  r_pid   <= ct_din[28:24];
                  r_ovfl  <= ct_din[2];
                  r_n     <= w_st_n;
                  r_trunc <= (ct_din[15:8] > SLOTS);
                  r_idx   <= 8'd0;
                  r_wait  <= ct_gnt;
                  if (w_st_n != 8'd0) begin
                     r_state <= S_READ;
                     if (ct_gnt) begin
                        r_stb  <= 1'b1;
                        r_we   <= 1'b0;
                        r_addr <= 1'b0;
                     end
                  end else begin
                     r_state <= S_UNFREEZE;
                     if (ct_gnt) begin
                        r_stb  <= 1'b1;
                        r_we   <= 1'b1;
                        r_addr <= 1'b1;
                        r_dout <= CMD_UNFREEZE;
                     end
                  end
               end else begin
                  r_wait <= ct_gnt;
                  if (ct_gnt) begin
                     r_stb  <= 1'b1;
                     r_we   <= 1'b0;
                     r_addr <= 1'b1;
                  end
               end
            end
            S_READ: begin
               r_wait <= ct_gnt;
               if (r_wait && ct_ack) begin
                  r_idx <= w_idx_nxt;
                  if (w_last_rd) begin
                     r_state <= S_UNFREEZE;
                     if (ct_gnt) begin
                        r_stb  <= 1'b1;
                        r_we   <= 1'b1;
                        r_addr <= 1'b1;
                        r_dout <= CMD_UNFREEZE;
                     end
                  end else if (ct_gnt) begin
                     r_stb  <= 1'b1;
                     r_we   <= 1'b0;
                     r_addr <= 1'b0;
                  end
               end else if (ct_gnt) begin
                  r_stb  <= 1'b1;
                  r_we   <= 1'b0;
                  r_addr <= 1'b0;
               end
            end
            S_UNFREEZE: begin
               if (r_wait && ct_ack) begin
                  r_count <= r_n;
                  r_valid <= 1'b1;
                  r_busy  <= 1'b0;
                  r_wait  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_wait <= ct_gnt;
                  if (ct_gnt) begin
                     r_stb  <= 1'b1;
                     r_we   <= 1'b1;
                     r_addr <= 1'b1;
                     r_dout <= CMD_UNFREEZE;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Snapshot storage; contents are not reset.
   always_ff @(posedge clk) begin
      if (w_buf_we) r_buf[r_idx[IW-1:0]] <= ct_din[23:0];
   end

   always_comb begin
      data_out = 32'h0;
      if (stb && !we) begin
         case (addr)
            2'd0:    data_out = {r_valid, r_busy, r_trunc, r_ovfl, 3'b000, r_pid, 12'h000, r_count};
            2'd1:    data_out = {8'h00, w_buf_rd};
            default: data_out = 32'h0;
         endcase
      end
   end

endmodule

// File: tb/tb_calltrace_snap.sv
// Directed bench for calltrace_snap with a small calltrace stack model.
module tb_calltrace_snap;

   logic        clk = 1'b0;
   logic        rst, trig, ct_req, ct_gnt, ct_stb, ct_we, ct_addr, ct_ack;
   logic [23:0] ct_dout;
   logic [31:0] ct_din;
   logic        stb, we, ack;
   logic [1:0]  addr;
   logic [31:0] data_in, data_out;

   calltrace_snap #(.num_slots(32)) dut (
      .clk(clk), .rst(rst), .trig(trig),
      .ct_req(ct_req), .ct_gnt(ct_gnt), .ct_stb(ct_stb), .ct_we(ct_we),
      .ct_addr(ct_addr), .ct_dout(ct_dout), .ct_din(ct_din), .ct_ack(ct_ack),
      .stb(stb), .we(we), .addr(addr), .data_in(data_in),
      .data_out(data_out), .ack(ack)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // calltrace stack model: status on ctrl read, pop top on data read
   logic [23:0] m_stk [256];
   logic [7:0]  m_base = 8'd0, m_pops = 8'd0, m_eff;
   logic [4:0]  m_pid = 5'd0;
   logic        m_ovfl = 1'b0, m_load = 1'b0;
   assign m_eff  = m_base - m_pops;
   assign ct_ack = ct_stb;

   always_comb begin
      ct_din = 32'h0;
      if (ct_addr) ct_din = {3'b000, m_pid, 8'h00, m_eff, 5'b00000, m_ovfl, 2'b00};
      else if (m_eff != 8'd0) ct_din = {8'h00, m_stk[m_eff - 8'd1]};
   end

   always @(posedge clk) begin
      if (m_load) m_pops <= 8'd0;
      else if (ct_stb && ct_ack && !ct_we && !ct_addr && m_eff != 8'd0) m_pops <= m_pops + 8'd1;
   end

   // Strobe log; stamp = edge at which the strobe was registered.
   logic [31:0] log_w [$];
   int          log_c [$];
   logic        g_prev = 1'b1;
   int          nogrant = 0;
   bit          gnt_toggle = 1'b0;
   always @(posedge clk) g_prev = ct_gnt;
   always @(negedge clk) begin
      if (ct_stb) begin
         log_w.push_back({6'b0, ct_we, ct_addr, ct_we ? ct_dout : 24'h0});
         log_c.push_back(cyc);
         if (!g_prev) nogrant++;
      end
      if (gnt_toggle) ct_gnt = ~ct_gnt;
   end

   int n_chk = 0, n_fail = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic load_stack(input int n, input logic [23:0] first, input logic [23:0] step,
                             input logic [4:0] pid, input logic ovfl);
      @(negedge clk);
      for (int i = 0; i < n; i++) m_stk[i] = first + 24'(i) * step;
      m_base = 8'(n); m_pid = pid; m_ovfl = ovfl; m_load = 1'b1;
      @(posedge clk); #1 m_load = 1'b0;
   endtask

   task automatic cpu_wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk); stb = 1'b1; we = 1'b1; addr = a; data_in = d;
      @(posedge clk); #1 stb = 1'b0; we = 1'b0;
   endtask

   task automatic cpu_rd(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk); stb = 1'b1; we = 1'b0; addr = a;
      #1 d = data_out;
      @(posedge clk); #1 stb = 1'b0;
   endtask

   task automatic pulse_trig(output int t);
      @(negedge clk); trig = 1'b1; t = cyc + 1;
      @(negedge clk); trig = 1'b0;
   endtask

   task automatic wait_valid(output int vc);
      bit got = 1'b0;
      vc = -1;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk); stb = 1'b1; we = 1'b0; addr = 2'd0;
         #1 if (data_out[31]) begin got = 1'b1; vc = cyc; end
      end
      stb = 1'b0;
      check_eq("valid_timeout", 32'(got), 32'd1);
   endtask

   task automatic check_dump(input int base, input int t, input int n, input bit chk_t);
      logic [31:0] w;
      check_eq("dump_len", 32'(log_w.size() - base), 32'(n + 3));
      if (log_w.size() >= base + n + 3) begin
         for (int i = 0; i < n + 3; i++) begin
            if (i == 0)          w = {6'b0, 1'b1, 1'b1, 24'h000004};
            else if (i == 1)     w = {6'b0, 1'b0, 1'b1, 24'h000000};
            else if (i == n + 2) w = {6'b0, 1'b1, 1'b1, 24'h000008};
            else                 w = 32'h0;
            check_eq($sformatf("dump_word%0d", i), log_w[base + i], w);
            if (chk_t) check_eq($sformatf("dump_cyc%0d", i), 32'(log_c[base + i]), 32'(t + 1 + i));
         end
      end
   endtask

   initial begin
      int t, vc, base, reqs;
      logic [31:0] d;
      rst = 1'b1; trig = 1'b0; ct_gnt = 1'b1;
      stb = 1'b0; we = 1'b0; addr = 2'd0; data_in = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_req", 32'(ct_req), 0);
      check_eq("rst_stb", 32'(ct_stb), 0);
      check_eq("rst_bus", {7'b0, ct_we, ct_addr, ct_dout}, 0);
      rst = 1'b0;
      cpu_rd(2'd0, d);
      check_eq("rst_status", d, 32'h0);

      // 3-deep stack, continuous grant
      load_stack(3, 24'h000100, 24'h000100, 5'd5, 1'b0);
      base = log_w.size();
      pulse_trig(t);
      wait_valid(vc);
      check_eq("n3_valid_cyc", 32'(vc), 32'(t + 7));
      check_dump(base, t, 3, 1'b1);
      cpu_rd(2'd0, d); check_eq("n3_status", d, 32'h8050_0003);
      cpu_rd(2'd1, d); check_eq("n3_buf0", d, 32'h0000_0300);
      cpu_rd(2'd1, d); check_eq("n3_buf1", d, 32'h0000_0200);
      cpu_rd(2'd1, d); check_eq("n3_buf2", d, 32'h0000_0100);

      // trigger while a snapshot is held is dropped
      base = log_w.size(); reqs = 0;
      pulse_trig(t);
      repeat (6) begin @(negedge clk); if (ct_req) reqs++; end
      check_eq("held_req", 32'(reqs), 0);
      check_eq("held_strobes", 32'(log_w.size() - base), 0);

      // empty stack, clear and software trigger in one write
      load_stack(0, 24'h0, 24'h0, 5'd2, 1'b0);
      base = log_w.size();
      t = cyc + 1;
      cpu_wr(2'd0, 32'h3);
      wait_valid(vc);
      check_eq("n0_valid_cyc", 32'(vc), 32'(t + 4));
      check_dump(base, t, 0, 1'b1);
      cpu_rd(2'd0, d); check_eq("n0_status", d, 32'h8020_0000);

      // 40 entries against 32 slots: truncated dump
      load_stack(40, 24'h010000, 24'h000001, 5'd31, 1'b1);
      cpu_wr(2'd0, 32'h1);
      cpu_rd(2'd0, d); check_eq("clr_status", d, 32'h0020_0000);
      base = log_w.size();
      pulse_trig(t);
      wait_valid(vc);
      check_eq("n40_valid_cyc", 32'(vc), 32'(t + 36));
      check_dump(base, t, 32, 1'b1);
      cpu_rd(2'd0, d); check_eq("n40_status", d, 32'hB1F0_0020);
      cpu_rd(2'd1, d); check_eq("n40_buf0", d, 32'h0001_0027);
      cpu_rd(2'd1, d); check_eq("n40_buf1", d, 32'h0001_0026);
      cpu_wr(2'd1, 32'd31);
      cpu_rd(2'd1, d); check_eq("n40_buf31", d, 32'h0001_0008);
      cpu_rd(2'd1, d); check_eq("n40_wrap", d, 32'h0001_0027);

      // grant toggling every cycle
      load_stack(3, 24'h000100, 24'h000100, 5'd5, 1'b0);
      cpu_wr(2'd0, 32'h1);
      base = log_w.size(); reqs = nogrant;
      gnt_toggle = 1'b1;
      pulse_trig(t);
      wait_valid(vc);
      gnt_toggle = 1'b0;
      @(negedge clk); ct_gnt = 1'b1;
      check_eq("tog_nogrant", 32'(nogrant - reqs), 0);
      check_dump(base, t, 3, 1'b0);
      cpu_rd(2'd0, d); check_eq("tog_status", d, 32'h8050_0003);
      cpu_rd(2'd1, d); check_eq("tog_buf0", d, 32'h0000_0300);
      cpu_rd(2'd1, d); check_eq("tog_buf1", d, 32'h0000_0200);
      cpu_rd(2'd1, d); check_eq("tog_buf2", d, 32'h0000_0100);

      // reset in the middle of the data reads
      load_stack(3, 24'h000100, 24'h000100, 5'd5, 1'b0);
      cpu_wr(2'd0, 32'h1);
      pulse_trig(t);
      while (cyc < t + 4) @(negedge clk);
      check_eq("mid_read_stb", {30'b0, ct_stb, ct_addr}, 32'h2);
      rst = 1'b1;
      @(negedge clk);
      check_eq("mid_rst_req", 32'(ct_req), 0);
      check_eq("mid_rst_stb", 32'(ct_stb), 0);
      check_eq("mid_rst_bus", {7'b0, ct_we, ct_addr, ct_dout}, 0);
      stb = 1'b1; we = 1'b0; addr = 2'd0;
      #1 check_eq("mid_rst_status", data_out, 32'h0);
      stb = 1'b0;
      @(negedge clk); rst = 1'b0;
      base = log_w.size(); reqs = 0;
      repeat (10) begin @(negedge clk); if (ct_req) reqs++; end
      check_eq("post_rst_req", 32'(reqs), 0);
      check_eq("post_rst_strobes", 32'(log_w.size() - base), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
